// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and constants for the stream demultiplexer
package stream_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } demux_state_e;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register for a single demux channel
module demux_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          valid,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic          last
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;

    // A load wins over a drain so the slot can empty and refill in one cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet demultiplexer, optional drop counter via STREAM_DEMUX_DROP_CNT_EN
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int DW   = 8,
    localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [SW-1:0]     in_sel,
    input  logic              in_last,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [N_CH*DW-1:0] out_data,
`ifdef STREAM_DEMUX_DROP_CNT_EN
    output logic [N_CH-1:0]   out_last,
    output logic [DROP_CNT_W-1:0] drop_cnt
`else
    output logic [N_CH-1:0]   out_last
`endif
);

    localparam logic [SW:0] N_CH_L = (SW+1)'(N_CH);

    demux_state_e  state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] eff_sel;
    logic          tgt_ok;
    logic          tgt_busy;
    logic          accept;
    logic [N_CH-1:0] match;
    logic [N_CH-1:0] load;

    // Mid-packet beats follow the latched select; an out-of-range select discards the packet.
    always_comb begin
        eff_sel  = (state_q == BUSY) ? sel_q : in_sel;
        tgt_ok   = ({1'b0, eff_sel} < N_CH_L);
        tgt_busy = 1'b0;
        match    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (tgt_ok && (eff_sel == SW'(k))) begin
                match[k] = 1'b1;
                tgt_busy = out_valid[k] && !out_ready[k];
            end
        end
        in_ready = !tgt_busy;
        accept   = in_valid && in_ready;
        load     = match & {N_CH{accept}};

        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d = BUSY;
                    sel_d   = in_sel;
                end
            end
            BUSY: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .load_last (in_last),
            .valid     (out_valid[k]),
            .ready     (out_ready[k]),
            .data      (out_data[k*DW +: DW]),
            .last      (out_last[k])
        );
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !tgt_ok && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
